ins_cache: RTL

Direct-mapped, read-only instruction cache; the responder side of the fetch interface (addr_to_icache → hit/ins).
- Answers fetch lookups combinationally.
- On a miss, refills one 16-byte line from the memory controller, one word request at a time.
- Sits between the fetch unit and the memory controller/arbiter. It has no write path and takes no part in branch recovery.

---
 rtl/ins_cache_pkg.sv | 5 +
 rtl/ins_cache.sv | 78 +++++++
 2 files changed

// File: rtl/ins_cache_pkg.sv
// ins_cache_pkg: shared state encoding and address-field widths for the instruction cache
package ins_cache_pkg;
   localparam int OFFSET_BITS = 4;
   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;
endpackage

// File: rtl/ins_cache.sv
// ins_cache: direct-mapped read-only instruction cache with a word-at-a-time line refill
module ins_cache
   import ins_cache_pkg::*;
#(
   parameter int INDEX_BITS = 4,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [31:0] addr,
   output logic        hit,
   output logic [31:0] ins,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data
);
   localparam int LINES = 2 ** INDEX_BITS;
   localparam int TAG_BITS = 32 - OFFSET_BITS - INDEX_BITS;
   state_t                state;
   logic [LINES-1:0]      valid;
   logic [TAG_BITS-1:0]   tag_arr [LINES];
   logic [31:0]           data_arr [LINES][LINE_WORDS];
   logic [TAG_BITS-1:0]   tag, fill_tag;
   logic [INDEX_BITS-1:0] idx, fill_idx;
   logic [1:0]            word, cnt;
   logic                  take, last;
   logic                  unused_bits;
   assign tag = addr[31:OFFSET_BITS+INDEX_BITS];
   assign idx = addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
   assign word = addr[3:2];
   assign unused_bits = ^addr[1:0];
   assign hit = valid[idx] && tag_arr[idx] == tag;
   assign ins = data_arr[idx][word];
   assign take = rdy && state == FILL && mem_done;
   assign last = cnt == 2'(LINE_WORDS - 1);
   // Control: miss detection, fill sequencing and line commit; reset abandons any fill
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         state <= IDLE;
         mem_req <= 1'b0;
         mem_addr <= '0;
         cnt <= '0;
         fill_idx <= '0;
         fill_tag <= '0;
      end else if (rdy) begin
         if (state == IDLE) begin
            if (!hit) begin
               fill_idx <= idx;
               fill_tag <= tag;
               valid[idx] <= 1'b0;
               mem_addr <= {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
               mem_req <= 1'b1;
               cnt <= '0;
               state <= FILL;
            end
         end else if (mem_done) begin
            if (last) begin
               valid[fill_idx] <= 1'b1;
               mem_req <= 1'b0;
               state <= IDLE;
            end else begin
               cnt <= cnt + 2'd1;
               mem_addr <= mem_addr + 32'd4;
            end
         end
      end
   end
   // Storage: returned words land in the line being filled; the tag is written with the last word
   always_ff @(posedge clk) begin
      if (take) begin
         data_arr[fill_idx][cnt] <= mem_data;
         if (last) tag_arr[fill_idx] <= fill_tag;
      end
   end
endmodule
